// File: rtl/mul_hilo_ctrl.sv
// rtl/mul_hilo_ctrl.sv - sequencing and HI/LO result registers around a combinational multiplier
//
// Latches operands for the external combinational signed multiplier, holds them
// stable for LATENCY settle cycles, then captures the 2*WIDTH product into HI/LO
// and pulses done. HI/LO can also be written directly from the bus.
//
// Optional feature macro: MUL_OVF_FLAG_EN (registered product overflow flag).
//
// Ports:
//   clock       rising-edge clock
//   clear       synchronous active-high reset
//   start       request a multiply of a_in x b_in
//   a_in, b_in  operands (Q, M)
//   q_out/m_out registered operands driving the multiplier
//   product_in  multiplier result, two's complement, 2*WIDTH bits
//   bus_in      direct-write data for HI/LO
//   hi_load     write bus_in to HI
//   lo_load     write bus_in to LO
//   busy        multiply in progress (RUN or CAPTURE)
//   done        one-cycle completion pulse
//   hi_out      HI register (upper product half)
//   lo_out      LO register (lower product half)
//   ovf         product does not fit in WIDTH bits (0 unless MUL_OVF_FLAG_EN)

module mul_hilo_ctrl #(
  parameter int LATENCY = 2,
  parameter int WIDTH   = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [WIDTH-1:0]   q_out,
  output logic [WIDTH-1:0]   m_out,
  input  logic [2*WIDTH-1:0] product_in,
  input  logic [WIDTH-1:0]   bus_in,
  input  logic               hi_load,
  input  logic               lo_load,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi_out,
  output logic [WIDTH-1:0]   lo_out,
  output logic               ovf
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             capture;

  assign capture = (state_q == S_CAPTURE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    m_d     = m_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          q_d     = a_in;
          m_d     = b_in;
          cnt_d   = CNT_INIT;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == 4'd0) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_CAPTURE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // The capture write has priority over a direct bus load on the same edge.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (capture) begin
      hi_d = product_in[2*WIDTH-1:WIDTH];
      lo_d = product_in[WIDTH-1:0];
    end else begin
      if (hi_load) hi_d = bus_in;
      if (lo_load) lo_d = bus_in;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      q_q     <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

`ifdef MUL_OVF_FLAG_EN
  logic ovf_q, ovf_d;

  // Overflow when the upper half is not a pure sign extension of the lower half's MSB.
  always_comb begin
    ovf_d = ovf_q;
    if (capture) begin
      ovf_d = |(product_in[2*WIDTH-1:WIDTH] ^ {WIDTH{product_in[WIDTH-1]}});
    end else if (hi_load || lo_load) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy   = (state_q == S_RUN) || (state_q == S_CAPTURE);
  assign done   = done_q;
  assign q_out  = q_q;
  assign m_out  = m_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// tb/tb_mul_hilo_ctrl.sv - scoreboard bench for mul_hilo_ctrl with a behavioural multiplier model

module tb_mul_hilo_ctrl;

  localparam int L = 2;
  localparam int W = 32;

`ifdef MUL_OVF_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  a_in = '0, b_in = '0, bus_in = '0;
  logic          hi_load = 1'b0, lo_load = 1'b0;
  logic [W-1:0]  q_out, m_out, hi_out, lo_out;
  logic [2*W-1:0] product_in;
  logic          busy, done, ovf;

  always #5 clock = ~clock;

  // Stand-in for the combinational signed multiplier.
  always_comb begin
    product_in = $signed({{W{q_out[W-1]}}, q_out}) * $signed({{W{m_out[W-1]}}, m_out});
  end

  mul_hilo_ctrl #(.LATENCY(L), .WIDTH(W)) dut (
    .clock(clock), .clear(clear), .start(start),
    .a_in(a_in), .b_in(b_in), .q_out(q_out), .m_out(m_out),
    .product_in(product_in), .bus_in(bus_in),
    .hi_load(hi_load), .lo_load(lo_load),
    .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out), .ovf(ovf)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         ov;
  } exp_t;

  exp_t sbq[$];

  // Reference model: edge index e, pending capture edge pc (-1 none), product pp.
  int           e = 0;
  int           pc = -1;
  int           next_ok = 0;
  longint       pp = 0;
  logic [W-1:0] mh = '0, ml = '0, mq = '0, mm = '0;
  logic         mo = 1'b0, mdone = 1'b0;

  function automatic logic ovf_of(input longint p);
    longint lim;
    lim = 2147483647;
    return (p > lim) || (p < -lim - 1);
  endfunction

  task automatic cycle(input logic st, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic hl, input logic ll, input logic [W-1:0] bus, input logic clr);
    logic   cap;
    longint sa, sb;
    exp_t   x;
    start = st; a_in = a; b_in = b; hi_load = hl; lo_load = ll; bus_in = bus; clear = clr;
    @(posedge clock);
    if (clr) begin
      if (pc >= 0) void'(sbq.pop_back());
      mh = '0; ml = '0; mq = '0; mm = '0; mo = 1'b0; mdone = 1'b0;
      pc = -1;
      next_ok = e + 1;
    end else begin
      cap = (pc == e);
      mdone = cap;
      if (st && e >= next_ok) begin
        mq = a; mm = b;
        sa = $signed(a);
        sb = $signed(b);
        pp = sa * sb;
        pc = e + L + 1;
        next_ok = e + L + 2;
        x.hi = pp[63:32];
        x.lo = pp[31:0];
        x.ov = OVF_EN && ovf_of(pp);
        sbq.push_back(x);
      end
      if (cap) begin
        mh = pp[63:32];
        ml = pp[31:0];
        mo = OVF_EN && ovf_of(pp);
        pc = -1;
      end else begin
        if (hl) mh = bus;
        if (ll) ml = bus;
        if (hl || ll) mo = 1'b0;
      end
    end
    e++;
    #1;
    chk("busy", 64'(busy), 64'(pc >= 0));
    chk("done", 64'(done), 64'(mdone));
    chk("hi_out", 64'(hi_out), 64'(mh));
    chk("lo_out", 64'(lo_out), 64'(ml));
    chk("q_out", 64'(q_out), 64'(mq));
    chk("m_out", 64'(m_out), 64'(mm));
    chk("ovf", 64'(ovf), 64'(mo));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic mul(input logic [W-1:0] a, input logic [W-1:0] b);
    cycle(1'b1, a, b, 1'b0, 1'b0, '0, 1'b0);
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 4))
      0: return 32'h8000_0000;
      1: return 32'h7fff_ffff;
      2: return W'($signed($urandom_range(0, 20)) - 10);
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding multiply.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("spurious_done", 64'(done), 64'd0);
      end else begin
        exp_t x;
        x = sbq.pop_front();
        chk("sb_hi", 64'(hi_out), 64'(x.hi));
        chk("sb_lo", 64'(lo_out), 64'(x.lo));
        chk("sb_ovf", 64'(ovf), 64'(x.ov));
      end
    end
  end

  initial begin
    cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hi", 64'(hi_out), 64'd0);

    mul(32'd3, 32'd5);
    idle(4);
    chk("lo_3x5", 64'(lo_out), 64'h0000_000F);
    chk("hi_3x5", 64'(hi_out), 64'h0);

    mul(-32'sd7, 32'd6);
    idle(4);
    chk("hi_m7x6", 64'(hi_out), 64'hFFFF_FFFF);
    chk("lo_m7x6", 64'(lo_out), 64'hFFFF_FFD6);

    mul(32'h8000_0000, 32'h8000_0000);
    idle(4);
    chk("hi_min2", 64'(hi_out), 64'h4000_0000);
    chk("ovf_min2", 64'(ovf), 64'(OVF_EN));

    // Start while busy is dropped; start in the done cycle is accepted.
    mul(32'd2, 32'd3);
    mul(32'd9, 32'd9);
    idle(2);
    chk("lo_ignore_busy", 64'(lo_out), 64'd6);
    mul(32'd2, 32'd3);
    idle(3);
    chk("lo_done_cycle", 64'(lo_out), 64'd6);
    chk("done_b2b", 64'(done), 64'd1);
    idle(1);

    cycle(1'b0, '0, '0, 1'b1, 1'b0, 32'h1234_5678, 1'b0);
    chk("hi_load", 64'(hi_out), 64'h1234_5678);
    chk("lo_keep", 64'(lo_out), 64'd6);

    // hi_load on the capture edge loses to the product.
    mul(32'd1, 32'd1);
    idle(2);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
    chk("cap_wins_hi", 64'(hi_out), 64'h0);
    chk("cap_wins_lo", 64'(lo_out), 64'h1);

    mul(32'd5, 32'd7);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_q", 64'(q_out), 64'd0);
    idle(5);

    for (int i = 0; i < 800; i++) begin
      cycle(($urandom % 3) == 0, rnd_op(), rnd_op(),
            ($urandom % 8) == 0, ($urandom % 8) == 0, $urandom,
            ($urandom % 100) == 0);
    end
    idle(6);
    chk("sb_empty", 64'(sbq.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
